sum_pipe_addsub: RTL and testbench

- Parametrised, pipelined successor to the single-cycle A+B+1 adder in the sum library.
- Performs add, increment-add (A+B+1), subtract and subtract-with-borrow on WIDTH-bit operands.
- Splits the carry chain into CHUNK-bit segments, one per register stage, so wide sums close timing on iCE40 carry chains.
- Sits between the operand mux and the ALU result mux, with a valid/ready handshake on both sides.

---
 rtl/sum_pipe_addsub_if.sv | 28 ++
 rtl/sum_pipe_addsub.sv | 134 +++++++++++++
 tb/tb_sum_pipe_addsub.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sum_pipe_addsub_if.sv
// Valid/ready operand and result bundle for the pipelined add/sub unit.
// The master drives operands and consumes results; the slave is the adder.
interface sum_pipe_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/sum_pipe_addsub.sv
// Pipelined add / increment-add / subtract / subtract-with-borrow.
// The carry chain is cut into CHUNK-bit segments, one register stage each.
module sum_pipe_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic              clk,
  input logic              rst,
  sum_pipe_addsub_if.slave bus
);
  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  function automatic logic [CHUNK:0] add_chunk(
    input logic [CHUNK-1:0] x,
    input logic [CHUNK-1:0] y,
    input logic             c
  );
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
  endfunction

  function automatic logic [WIDTH-1:0] put_chunk(
    input logic [WIDTH-1:0] s,
    input int               idx,
    input logic [CHUNK-1:0] c
  );
    logic [WIDTH-1:0] r;
    r = s;
    r[idx*CHUNK +: CHUNK] = c;
    return r;
  endfunction

  logic             w_en;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;

  logic [WIDTH-1:0] r_a_p0;
  logic [WIDTH-1:0] r_b_p0;
  logic             r_c_p0;
  logic             r_vld_p0;

  logic [WIDTH-1:0] r_a_pn   [STAGES];
  logic [WIDTH-1:0] r_b_pn   [STAGES];
  logic [WIDTH-1:0] r_sum_pn [STAGES];
  logic             r_cy_pn  [STAGES];
  logic             r_vld_pn [STAGES];
  logic             r_cmsb;

  logic [WIDTH-1:0] w_a_src [STAGES];
  logic [WIDTH-1:0] w_b_src [STAGES];
  logic [WIDTH-1:0] w_s_src [STAGES];
  logic             w_c_src [STAGES];
  logic             w_v_src [STAGES];
  logic [CHUNK:0]   w_add   [STAGES];
  logic [WIDTH-1:0] w_s_nxt [STAGES];
  logic             w_cmsb;

  // One enable for the whole pipe: it only stalls when the result is blocked.
  assign w_en         = ~r_vld_pn[LAST] | bus.out_ready;
  assign bus.in_ready = w_en;

  assign w_b_eff   = bus.op[1] ? ~bus.b : bus.b;
  assign w_cin_eff = (bus.op == 2'b01 || bus.op == 2'b10) ? 1'b1 : bus.cin;

  // ---- acceptance register: conditioned operands ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_p0   <= '0;
      r_b_p0   <= '0;
      r_c_p0   <= 1'b0;
      r_vld_p0 <= 1'b0;
    end else if (w_en) begin
      r_a_p0   <= bus.a;
      r_b_p0   <= w_b_eff;
      r_c_p0   <= w_cin_eff;
      r_vld_p0 <= bus.in_valid;
    end
  end

  assign w_a_src[0] = r_a_p0;
  assign w_b_src[0] = r_b_p0;
  assign w_s_src[0] = '0;
  assign w_c_src[0] = r_c_p0;
  assign w_v_src[0] = r_vld_p0;

  for (genvar k = 1; k < STAGES; k++) begin : g_link
    assign w_a_src[k] = r_a_pn[k-1];
    assign w_b_src[k] = r_b_pn[k-1];
    assign w_s_src[k] = r_sum_pn[k-1];
    assign w_c_src[k] = r_cy_pn[k-1];
    assign w_v_src[k] = r_vld_pn[k-1];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_add
    assign w_add[k]   = add_chunk(w_a_src[k][k*CHUNK +: CHUNK],
                                  w_b_src[k][k*CHUNK +: CHUNK],
                                  w_c_src[k]);
    assign w_s_nxt[k] = put_chunk(w_s_src[k], k, w_add[k][CHUNK-1:0]);
  end

  // Carry into the MSB recovered from the MSB sum bit and its two addend bits.
  assign w_cmsb = w_add[LAST][CHUNK-1] ^ w_a_src[LAST][WIDTH-1] ^ w_b_src[LAST][WIDTH-1];

  // ---- chunk stages: stage k registers its partial sum and carry ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a_pn[k]   <= '0;
        r_b_pn[k]   <= '0;
        r_sum_pn[k] <= '0;
        r_cy_pn[k]  <= 1'b0;
        r_vld_pn[k] <= 1'b0;
      end
      r_cmsb <= 1'b0;
    end else if (w_en) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a_pn[k]   <= w_a_src[k];
        r_b_pn[k]   <= w_b_src[k];
        r_sum_pn[k] <= w_s_nxt[k];
        r_cy_pn[k]  <= w_add[k][CHUNK];
        r_vld_pn[k] <= w_v_src[k];
      end
      r_cmsb <= w_cmsb;
    end
  end

  // ---- output: last stage register drives the result bus ----
  assign bus.out_valid = r_vld_pn[LAST];
  assign bus.sum       = r_sum_pn[LAST];
  assign bus.cout      = r_cy_pn[LAST];
  assign bus.ovf       = r_cmsb ^ r_cy_pn[LAST];
  // Qualified by valid so the cleared output register does not report zero.
  assign bus.zero      = r_vld_pn[LAST] & (r_sum_pn[LAST] == '0);
endmodule

// File: tb/tb_sum_pipe_addsub.sv
// Directed and random checks of sum_pipe_addsub at WIDTH=8, CHUNK=4.
// Results are compared as {zero, ovf, cout, sum} against hand values or a model.
module tb_sum_pipe_addsub;
  localparam int W = 8;

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        ci;
    logic [10:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sum_pipe_addsub_if #(.WIDTH(W)) bus ();
  sum_pipe_addsub #(.WIDTH(W), .CHUNK(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          n_vec  = 0;
  int          n_err  = 0;
  int          n_sent = 0;
  int          n_recv = 0;
  int          cyc    = 0;
  logic [10:0] exp_q [$];
  logic        rand_on;
  vec_t        dv [9];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] model(input logic [1:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic ci);
    logic [7:0] be;
    logic       ce;
    logic [8:0] full;
    logic       c7;
    be   = op[1] ? ~b : b;
    ce   = (op == 2'b01 || op == 2'b10) ? 1'b1 : ci;
    full = {1'b0, a} + {1'b0, be} + {8'b0, ce};
    c7   = full[7] ^ a[7] ^ be[7];
    return {(full[7:0] == 8'h00), c7 ^ full[8], full[8], full[7:0]};
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input logic [10:0] exp);
    logic acc;
    int   t;
    acc = 1'b0;
    t   = 0;
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = ci;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    bus.in_valid = 1'b0;
    if (acc) begin
      exp_q.push_back(exp);
      n_sent++;
    end else begin
      chk("accept_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) wait_cycles(1);
    chk("drain", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      n_recv++;
      if (exp_q.size() == 0) chk("spurious_out", 32'd1, 32'd0);
      else chk("result", {bus.zero, bus.ovf, bus.cout, bus.sum}, exp_q.pop_front());
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got time limit, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.op = 2'b00;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_outputs", {bus.zero, bus.ovf, bus.cout, bus.sum}, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(1);

    // Latency on an empty pipe: 0xFF + 0x01 wraps to zero with carry out.
    send(2'b00, 8'hFF, 8'h01, 1'b0, 11'h500);
    chk("lat_n0", bus.out_valid, 0);
    wait_cycles(1);
    chk("lat_n1", bus.out_valid, 0);
    wait_cycles(1);
    chk("lat_n2", bus.out_valid, 1);
    drain();

    dv = '{
      '{2'b01, 8'h7F, 8'h00, 1'b0, 11'h280},
      '{2'b00, 8'h0F, 8'h01, 1'b0, 11'h010},
      '{2'b10, 8'h05, 8'h07, 1'b0, 11'h0FE},
      '{2'b11, 8'h10, 8'h01, 1'b0, 11'h10E},
      '{2'b10, 8'h80, 8'h01, 1'b1, 11'h37F},
      '{2'b11, 8'h05, 8'h05, 1'b1, 11'h500},
      '{2'b01, 8'h01, 8'h02, 1'b0, 11'h004},
      '{2'b10, 8'h07, 8'h05, 1'b0, 11'h102},
      '{2'b00, 8'h7F, 8'h00, 1'b1, 11'h280}
    };
    c0 = cyc;
    for (int i = 0; i < 9; i++) send(dv[i].op, dv[i].a, dv[i].b, dv[i].ci, dv[i].exp);
    chk("throughput_cycles", cyc - c0, 9);
    drain();

    // Backpressure: stall the first result for three cycles.
    fork
      begin
        for (int k = 1; k <= 4; k++) send(2'b00, k[7:0], 8'(16 * k), 1'b0, 11'(17 * k));
      end
      begin
        int t;
        t = 0;
        while (bus.out_valid !== 1'b1 && t < 20) begin
          wait_cycles(1);
          t++;
        end
        chk("stall_first_valid", bus.out_valid, 1);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          wait_cycles(1);
          chk("stall_hold", {bus.out_valid, bus.zero, bus.ovf, bus.cout, bus.sum}, 12'h811);
          chk("stall_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with one result showing and two beats behind it.
    send(2'b00, 8'h01, 8'h01, 1'b0, 11'h002);
    send(2'b00, 8'h02, 8'h02, 1'b0, 11'h004);
    send(2'b00, 8'h03, 8'h03, 1'b0, 11'h006);
    chk("pre_rst_out", {bus.out_valid, bus.zero, bus.ovf, bus.cout, bus.sum}, 12'h802);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_outputs", {bus.zero, bus.ovf, bus.cout, bus.sum}, 0);
    exp_q.delete();
    n_sent -= 3;
    #20;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_cycles(1);
      chk("post_rst_stale", bus.out_valid, 0);
    end
    send(2'b01, 8'hAA, 8'h55, 1'b0, 11'h500);
    wait_cycles(1);
    chk("post_rst_lat1", bus.out_valid, 0);
    wait_cycles(1);
    chk("post_rst_lat2", bus.out_valid, 1);
    drain();

    // Random traffic with bubbles carrying junk data and random backpressure.
    rand_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 2000; i++) begin
          logic [1:0] op;
          logic [7:0] a;
          logic [7:0] b;
          logic       ci;
          op = 2'($urandom);
          a  = 8'($urandom);
          b  = 8'($urandom);
          ci = 1'($urandom);
          while ($urandom_range(0, 3) == 0) begin
            bus.in_valid = 1'b0;
            bus.a  = 8'($urandom);
            bus.b  = 8'($urandom);
            bus.op = 2'($urandom);
            wait_cycles(1);
          end
          send(op, a, b, ci, model(op, a, b, ci));
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          bus.out_ready = ($urandom_range(0, 2) != 0);
          wait_cycles(1);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("beat_count", n_recv, n_sent);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
